cache_avl_mem_slave: RTL and testbench

- Avalon-MM burst-capable responder: on-chip word memory answering the cache bus master port (burst line fills, single-word IO/write-through traffic).
- Serves as the memory end of the cache refill/write-back path in both integration and unit benches.
- Accepts burst reads and writes with waitRequest flow control; returns ordered, pipelined readData/readDataValid at a fixed latency.

---
 rtl/cache_avl_pkg.sv | 25 ++
 rtl/cache_avl_rd_pipe.sv | 41 ++++
 rtl/cache_avl_mem_slave.sv | 140 ++++++++++++++
 tb/tb_cache_avl_mem_slave.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_avl_pkg.sv
// Shared definitions for the cache Avalon-MM memory responder.
// Optional build macro CACHE_AVL_MEM_STALL_EN (LFSR-driven random waitRequest)
// is consumed by cache_avl_mem_slave; constants for it live here.
`ifndef CACHE_AVALON_BURST_COUNT_WIDTH
`define CACHE_AVALON_BURST_COUNT_WIDTH 4
`endif

package cache_avl_pkg;

    // Responder command state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } avl_state_e;

    // Stall LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Legal read-latency range
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/cache_avl_rd_pipe.sv
// Fixed-latency read-return delay line with asynchronous flush.
// Beats enter in issue order and leave STAGES cycles later, so ordering and
// back-to-back contiguity are inherited directly from the issue stream.
module cache_avl_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic              any_vld
);

    logic [STAGES-1:0] vld_p;
    logic [DATA_W-1:0] data_p [STAGES];

    // Shift valid/data one stage per cycle; reset empties the pipe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < STAGES; i++) data_p[i] <= '0;
        end else begin
            // stage 0: memory word captured in its issue cycle
            vld_p[0]  <= in_vld;
            data_p[0] <= in_data;
            // stages 1..STAGES-1: pure delay
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_vld  = vld_p[STAGES-1];
    assign out_data = data_p[STAGES-1];
    assign any_vld  = |vld_p;

endmodule

// File: rtl/cache_avl_mem_slave.sv
// Avalon-MM burst responder backed by an on-chip word memory.
// Build option: define CACHE_AVL_MEM_STALL_EN to inject pseudo-random
// waitRequest cycles in IDLE/WR from an 8-bit LFSR.
`ifndef CACHE_AVALON_BURST_COUNT_WIDTH
`define CACHE_AVALON_BURST_COUNT_WIDTH 4
`endif

module cache_avl_mem_slave
    import cache_avl_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2,
    parameter int BURST_W    = `CACHE_AVALON_BURST_COUNT_WIDTH
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        s_address,
    input  logic [3:0]         s_byteEnable,
    input  logic               s_read,
    input  logic               s_write,
    input  logic [31:0]        s_writeData,
    output logic               s_waitRequest,
    input  logic               s_beginBurstTransfer,
    input  logic [BURST_W-1:0] s_burstCount,
    output logic [31:0]        s_readData,
    output logic               s_readDataValid,
    output logic               busy
);

    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    avl_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BURST_W-1:0] cnt_q;
    logic [31:0]       mem [2**ADDR_W];

    logic [ADDR_W-1:0] cur_addr;
    logic              stall;
    logic              multi;
    logic              rd_accept;
    logic              wr_en;
    logic              issue_vld;
    logic [31:0]       rd_word;
    logic              pipe_busy;
    logic              unused_bits;

    // Burst framing is taken from s_burstCount; the marker and the
    // out-of-range address bits carry no information for this memory.
    assign unused_bits = ^{s_beginBurstTransfer, s_address[31:ADDR_W+2], s_address[1:0]};

`ifdef CACHE_AVL_MEM_STALL_EN
    logic [7:0] lfsr_q;

    // Free-running stall generator
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign stall = (lfsr_q[1:0] == 2'b11) && (state_q != RD);
`else
    assign stall = 1'b0;
`endif

    // In IDLE the command address is used directly; inside a burst the
    // latched, self-incrementing address is used and s_address is ignored.
    assign cur_addr  = (state_q == IDLE) ? s_address[ADDR_W+1:2] : addr_q;
    assign multi     = s_burstCount > ONE;
    // Write wins over a simultaneous read in IDLE, so the read is dropped
    assign rd_accept = (state_q == IDLE) && s_read && !s_write && !stall;
    assign wr_en     = (state_q != RD) && s_write && !stall;
    assign issue_vld = rd_accept || (state_q == RD);
    assign rd_word   = mem[cur_addr];

    assign s_waitRequest = (state_q == RD) || stall;
    assign busy          = (state_q != IDLE) || pipe_busy;

    // Command/burst sequencer
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((wr_en || rd_accept) && multi) begin
                        addr_q  <= cur_addr + 1'b1;
                        cnt_q   <= s_burstCount - ONE;
                        state_q <= wr_en ? WR : RD;
                    end
                end
                RD: begin
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_q - ONE;
                    if (cnt_q == ONE) state_q <= IDLE;
                end
                WR: begin
                    if (wr_en) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - ONE;
                        if (cnt_q == ONE) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte-lane memory write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (s_byteEnable[b]) mem[cur_addr][8*b +: 8] <= s_writeData[8*b +: 8];
            end
        end
    end

    cache_avl_rd_pipe #(
        .DATA_W (32),
        .STAGES (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst_n    (rest),
        .in_vld   (issue_vld),
        .in_data  (rd_word),
        .out_vld  (s_readDataValid),
        .out_data (s_readData),
        .any_vld  (pipe_busy)
    );

    // Master protocol misuse checks
    a_no_read_in_wr: assert property (@(posedge clk) disable iff (!rest)
        !(state_q == WR && s_read));
    a_no_rd_wr_idle: assert property (@(posedge clk) disable iff (!rest)
        !(state_q == IDLE && s_read && s_write));
    a_latency_range: assert property (@(posedge clk)
        (RD_LATENCY >= RD_LAT_MIN) && (RD_LATENCY <= RD_LAT_MAX));

endmodule

// File: tb/tb_cache_avl_mem_slave.sv
// Directed bench for cache_avl_mem_slave (default build, RD_LATENCY 2).
module tb_cache_avl_mem_slave;

    logic        clk;
    logic        rest;
    logic [31:0] s_address;
    logic [3:0]  s_byteEnable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writeData;
    logic        s_waitRequest;
    logic        s_beginBurstTransfer;
    logic [3:0]  s_burstCount;
    logic [31:0] s_readData;
    logic        s_readDataValid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    cache_avl_mem_slave #(
        .ADDR_W     (10),
        .RD_LATENCY (2),
        .BURST_W    (4)
    ) dut (
        .clk                  (clk),
        .rest                 (rest),
        .s_address            (s_address),
        .s_byteEnable         (s_byteEnable),
        .s_read               (s_read),
        .s_write              (s_write),
        .s_writeData          (s_writeData),
        .s_waitRequest        (s_waitRequest),
        .s_beginBurstTransfer (s_beginBurstTransfer),
        .s_burstCount         (s_burstCount),
        .s_readData           (s_readData),
        .s_readDataValid      (s_readDataValid),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        s_write = 1'b1; s_address = addr; s_writeData = data;
        s_byteEnable = be; s_burstCount = 4'd1; s_beginBurstTransfer = 1'b1;
        chk("wr_wait", 32'(s_waitRequest), 32'd0);
        step();
        s_write = 1'b0; s_beginBurstTransfer = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [31:0] addr, input logic [3:0] bc,
                       input logic [31:0] exp);
        s_read = 1'b1; s_address = addr; s_burstCount = bc; s_beginBurstTransfer = 1'b1;
        step();
        s_read = 1'b0; s_beginBurstTransfer = 1'b0;
        chk({tag, "_v1"}, 32'(s_readDataValid), 32'd0);
        step();
        chk({tag, "_v2"}, 32'(s_readDataValid), 32'd1);
        chk({tag, "_data"}, s_readData, exp);
        step();
        chk({tag, "_v3"}, 32'(s_readDataValid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wait"}, 32'(s_waitRequest), 32'd0);
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        rest = 1'b0; s_address = '0; s_byteEnable = '0; s_read = 1'b0;
        s_write = 1'b0; s_writeData = '0; s_beginBurstTransfer = 1'b0; s_burstCount = '0;
        step(); step();
        chk("rst_valid", 32'(s_readDataValid), 32'd0);
        chk("rst_data", s_readData, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wait", 32'(s_waitRequest), 32'd0);
        rest = 1'b1;
        step();

        // single write then read-after-write at T+1
        wr1(32'h10, 32'hDEADBEEF, 4'hF);
        rd1("raw", 32'h10, 4'd1, 32'hDEADBEEF);

        // byte-lane merge
        wr1(32'h20, 32'hFFFFFFFF, 4'hF);
        wr1(32'h20, 32'h12345678, 4'b0011);
        rd1("bytes", 32'h20, 4'd1, 32'hFFFF5678);

        // burstCount 0 behaves as a single beat
        rd1("bc0", 32'h20, 4'd0, 32'hFFFF5678);

        // burst write of 8 at 0x100 with a gap; s_address ignored mid-burst
        s_write = 1'b1; s_address = 32'h100; s_burstCount = 4'd8;
        s_byteEnable = 4'hF; s_writeData = 32'd0; s_beginBurstTransfer = 1'b1;
        step();
        s_beginBurstTransfer = 1'b0;
        s_address = 32'h10;
        for (int i = 1; i < 8; i++) begin
            if (i == 4) begin
                s_write = 1'b0;
                step();
                chk("wr_gap_busy", 32'(busy), 32'd1);
                s_write = 1'b1;
            end
            s_writeData = 32'(i);
            chk("wrb_wait", 32'(s_waitRequest), 32'd0);
            step();
        end
        s_write = 1'b0;
        chk("wrb_done_busy", 32'(busy), 32'd0);
        rd1("wrb_addr_ignored", 32'h10, 4'd1, 32'hDEADBEEF);

        // burst read of 8: waitRequest T+1..T+7, data T+2..T+9
        s_read = 1'b1; s_address = 32'h100; s_burstCount = 4'd8; s_beginBurstTransfer = 1'b1;
        chk("rdb_wait_t0", 32'(s_waitRequest), 32'd0);
        step();
        s_read = 1'b0; s_beginBurstTransfer = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("rdb_wait", 32'(s_waitRequest), 32'(c <= 7));
            chk("rdb_valid", 32'(s_readDataValid), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) chk("rdb_data", s_readData, 32'(c - 2));
            step();
        end
        chk("rdb_busy", 32'(busy), 32'd0);

        // back-to-back bursts of 4 -> 8 contiguous beats
        for (int c = 0; c <= 10; c++) begin
            s_read = 1'b0; s_beginBurstTransfer = 1'b0;
            if (c == 0) begin
                s_read = 1'b1; s_address = 32'h100; s_burstCount = 4'd4; s_beginBurstTransfer = 1'b1;
            end
            if (c == 4) begin
                s_read = 1'b1; s_address = 32'h110; s_burstCount = 4'd4; s_beginBurstTransfer = 1'b1;
            end
            chk("b2b_wait", 32'(s_waitRequest), 32'((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
            chk("b2b_valid", 32'(s_readDataValid), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) chk("b2b_data", s_readData, 32'(c - 2));
            step();
        end
        s_read = 1'b0; s_beginBurstTransfer = 1'b0;

        // address wrap 1022,1023,0,1 (word 1 written through alias 0x1004)
        wrap_exp[0] = 32'hA0000001; wrap_exp[1] = 32'hA0000002;
        wrap_exp[2] = 32'hA0000003; wrap_exp[3] = 32'hA0000004;
        wr1(32'hFF8, wrap_exp[0], 4'hF);
        wr1(32'hFFC, wrap_exp[1], 4'hF);
        wr1(32'h000, wrap_exp[2], 4'hF);
        wr1(32'h1004, wrap_exp[3], 4'hF);
        for (int c = 0; c <= 6; c++) begin
            s_read = (c == 0); s_beginBurstTransfer = (c == 0);
            s_address = 32'hFF8; s_burstCount = 4'd4;
            chk("wrap_valid", 32'(s_readDataValid), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) chk("wrap_data", s_readData, wrap_exp[c - 2]);
            step();
        end
        s_read = 1'b0; s_beginBurstTransfer = 1'b0;

        // reset in the middle of a burst read
        for (int c = 0; c <= 3; c++) begin
            s_read = (c == 0); s_beginBurstTransfer = (c == 0);
            s_address = 32'h100; s_burstCount = 4'd8;
            if (c >= 2) chk("mid_data", s_readData, 32'(c - 2));
            step();
        end
        s_read = 1'b0; s_beginBurstTransfer = 1'b0;
        chk("mid_pre_valid", 32'(s_readDataValid), 32'd1);
        chk("mid_pre_wait", 32'(s_waitRequest), 32'd1);
        rest = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(s_readDataValid), 32'd0);
        chk("mid_rst_wait", 32'(s_waitRequest), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        rest = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("post_valid", 32'(s_readDataValid), 32'd0);
        end
        chk("post_wait", 32'(s_waitRequest), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
